ysyx_22050854_mul_ctrl: RTL and testbench



---
 rtl/ysyx_22050854_mul_ctrl_pkg.sv | 16 +
 rtl/ysyx_22050854_mul_ctrl_tree.sv | 62 ++++++
 rtl/ysyx_22050854_mul_ctrl.sv | 70 +++++++
 tb/tb_ysyx_22050854_mul_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050854_mul_ctrl_pkg.sv
// ysyx_22050854_mul_ctrl_pkg: shared widths, state encoding and operand extension for the multiplier
package ysyx_22050854_mul_ctrl_pkg;
  localparam int XLEN = 64;
  localparam int OP_W = 66;
  localparam int TREE_W = 132;
  localparam int PROD_W = 128;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TREE = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;
  function automatic logic [OP_W-1:0] ext_op(input logic [XLEN-1:0] x, input logic s, input logic w);
    return w ? {{34{s & x[31]}}, x[31:0]} : {{2{s & x[63]}}, x};
  endfunction
endpackage

// File: rtl/ysyx_22050854_mul_ctrl_tree.sv
// ysyx_22050854_mul_tree: radix-4 Booth partial products reduced by a Wallace carry-save tree
module ysyx_22050854_mul_tree
  import ysyx_22050854_mul_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [TREE_W-1:0] sum,
  output logic [TREE_W-1:0] carry
);
  localparam int NPP = OP_W / 2;
  logic [TREE_W-1:0] pp [NPP];
  logic [NPP-1:0]    negs;
  logic [TREE_W-1:0] corr;
  logic [TREE_W-1:0] ax;
  logic [OP_W:0]     bx;
  assign ax = {{OP_W{a[OP_W-1]}}, a};
  assign bx = {b, 1'b0};
  for (genvar i = 0; i < NPP; i++) begin : g_pp
    logic [2:0]        t;
    logic [TREE_W-1:0] mag;
    assign t = bx[2*i+2:2*i];
    assign negs[i] = t[2] & ~&t;
    assign mag = (t == 3'b011 || t == 3'b100) ? ax << 1 : (t == 3'b000 || t == 3'b111) ? '0 : ax;
    // Negative digits use ~mag here; the +1 lands in the correction row at bit 2i
    assign pp[i] = (negs[i] ? ~mag : mag) << (2 * i);
  end
  always_comb begin
    corr = '0;
    for (int k = 0; k < NPP; k++) corr[2*k] = negs[k];
  end
  always_comb begin
    logic [TREE_W-1:0] r  [NPP+3];
    logic [TREE_W-1:0] nx [NPP+3];
    int n, m;
    for (int k = 0; k < NPP + 3; k++) r[k] = '0;
    for (int k = 0; k < NPP; k++) r[k] = pp[k];
    r[NPP] = corr;
    n = NPP + 1;
    for (int l = 0; l < 8; l++) begin
      for (int k = 0; k < NPP + 3; k++) nx[k] = '0;
      m = 0;
      for (int k = 0; k <= NPP; k += 3) begin
        if (k + 2 < n) begin
          nx[m] = r[k] ^ r[k+1] ^ r[k+2];
          nx[m+1] = ((r[k] & r[k+1]) | (r[k] & r[k+2]) | (r[k+1] & r[k+2])) << 1;
          m = m + 2;
        end else if (k < n) begin
          nx[m] = r[k];
          m = m + 1;
          if (k + 1 < n) begin
            nx[m] = r[k+1];
            m = m + 1;
          end
        end
      end
      r = nx;
      n = m;
    end
    sum = r[0];
    carry = r[1];
  end
endmodule

// File: rtl/ysyx_22050854_mul_ctrl.sv
// ysyx_22050854_mul_ctrl: sequences operand capture, tree, final add and result handshake
module ysyx_22050854_mul_ctrl
  import ysyx_22050854_mul_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            mul_valid,
  input  logic            flush,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic            mul_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);
  state_t state_q, state_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic w_q, w_d, out_valid_q, out_valid_d, acc, upd;
  logic [TREE_W-1:0] sum_q, sum_d, carry_q, carry_d, t_sum, t_carry;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [PROD_W-1:0] p;
  ysyx_22050854_mul_tree u_tree (.a(a_q), .b(b_q), .sum(t_sum), .carry(t_carry));
  assign mul_ready = state_q == S_IDLE;
  assign out_valid = out_valid_q;
  assign result_hi = hi_q;
  assign result_lo = lo_q;
  always_comb begin
    acc = mul_valid & mul_ready & ~flush;
    upd = state_q == S_ADD & ~flush;
    state_d = flush ? S_IDLE
            : state_q == S_IDLE ? (acc ? S_TREE : S_IDLE)
            : state_q == S_DONE ? (out_ready ? S_IDLE : S_DONE)
            : state_t'(state_q + 2'd1);
    a_d = acc ? ext_op(multiplicand, mul_signed[1], mulw) : a_q;
    b_d = acc ? ext_op(multiplier, mul_signed[0], mulw) : b_q;
    w_d = acc ? mulw : w_q;
    sum_d = state_q == S_TREE ? t_sum : sum_q;
    carry_d = state_q == S_TREE ? t_carry : carry_q;
    p = sum_q[PROD_W-1:0] + carry_q[PROD_W-1:0];
    hi_d = upd ? (w_q ? {XLEN{p[31]}} : p[127:64]) : hi_q;
    lo_d = upd ? (w_q ? {{32{p[31]}}, p[31:0]} : p[63:0]) : lo_q;
    out_valid_d = state_d == S_DONE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      w_q <= 1'b0;
      sum_q <= '0;
      carry_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      w_q <= w_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22050854_mul_ctrl.sv
// tb_ysyx_22050854_mul_ctrl: transaction-level reference model plus directed and random stimulus
module tb_ysyx_22050854_mul_ctrl;
  logic clock = 0, reset = 1, mul_valid = 0, flush = 0, mulw = 0, out_ready = 0;
  logic [1:0] mul_signed = 0;
  logic [63:0] multiplicand = 0, multiplier = 0;
  logic mul_ready, out_valid;
  logic [63:0] result_hi, result_lo;
  int tests = 0, fails = 0;
  bit armed = 0;
  ysyx_22050854_mul_ctrl dut (
    .clock(clock), .reset(reset), .mul_valid(mul_valid), .flush(flush), .mulw(mulw),
    .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_ready(mul_ready), .out_valid(out_valid), .out_ready(out_ready),
    .result_hi(result_hi), .result_lo(result_lo)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] s, input logic w);
    logic [127:0] x, y, p;
    x = w ? (s[1] ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]}) : (s[1] ? {{64{a[63]}}, a} : {64'b0, a});
    y = w ? (s[0] ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]}) : (s[0] ? {{64{b[63]}}, b} : {64'b0, b});
    p = x * y;
    return w ? {{96{p[31]}}, p[31:0]} : p;
  endfunction
  bit m_busy = 0, m_valid = 0;
  int m_age = 0;
  logic [127:0] m_res = 0, m_pend = 0;
  always @(posedge clock) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_res = 0;
    end else if (flush) begin
      m_busy = 0; m_valid = 0;
    end else if (!m_busy) begin
      if (mul_valid) begin
        m_busy = 1; m_age = 0;
        m_pend = ref_mul(multiplicand, multiplier, mul_signed, mulw);
      end
    end else if (m_age < 2) begin
      m_age++;
      if (m_age == 2) begin
        m_valid = 1; m_res = m_pend;
      end
    end else if (out_ready) begin
      m_busy = 0; m_valid = 0;
    end
  end
  always @(negedge clock) if (armed) begin
    chk("mul_ready", {127'b0, mul_ready}, {127'b0, !m_busy});
    chk("out_valid", {127'b0, out_valid}, {127'b0, m_valid});
    chk("result_hi", {64'b0, result_hi}, {64'b0, m_res[127:64]});
    chk("result_lo", {64'b0, result_lo}, {64'b0, m_res[63:0]});
  end
  task automatic step();
    @(posedge clock); #1;
  endtask
  task automatic do_op(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] s, input logic w, input logic [63:0] eh, input logic [63:0] el);
    int n;
    bit got;
    multiplicand = a; multiplier = b; mul_signed = s; mulw = w; mul_valid = 1; out_ready = 1;
    step();
    mul_valid = 0; multiplicand = $urandom; multiplier = $urandom;
    n = 0; got = 0;
    while (!got && n < 10) begin
      @(negedge clock);
      n++;
      if (!out_valid) chk({name, "_busy_ready"}, {127'b0, mul_ready}, 128'd0);
      got = out_valid;
    end
    chk({name, "_latency"}, n, 3);
    chk({name, "_hi"}, {64'b0, result_hi}, {64'b0, eh});
    chk({name, "_lo"}, {64'b0, result_lo}, {64'b0, el});
    step();
  endtask
  initial begin
    step();
    armed = 1;
    step();
    @(negedge clock);
    chk("reset_ready", {127'b0, mul_ready}, 128'd1);
    chk("reset_result", {result_hi, result_lo}, 128'd0);
    step();
    reset = 0;
    step();
    do_op("u3x5", 64'd3, 64'd5, 2'b00, 0, 64'd0, 64'd15);
    do_op("ss_m1", '1, '1, 2'b11, 0, 64'd0, 64'd1);
    do_op("su_m1", '1, '1, 2'b10, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    do_op("uu_m1", '1, '1, 2'b00, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
    do_op("mulw", 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 2'b11, 1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    multiplicand = 64'd7; multiplier = 64'd9; mul_signed = 0; mulw = 0; mul_valid = 1; out_ready = 0;
    step();
    multiplicand = 64'd11; multiplier = 64'd13;
    repeat (8) step();
    chk("bp_valid", {127'b0, out_valid}, 128'd1);
    chk("bp_lo", {64'b0, result_lo}, 128'd63);
    out_ready = 1;
    step();
    chk("bp_idle", {127'b0, mul_ready}, 128'd1);
    step();
    chk("bp_accept", {127'b0, mul_ready}, 128'd0);
    mul_valid = 0;
    repeat (4) step();
    chk("bp_second_lo", {64'b0, result_lo}, 128'd143);
    mul_valid = 1; multiplicand = 64'd100; multiplier = 64'd100;
    step();
    mul_valid = 0; flush = 1;
    step();
    flush = 0;
    chk("flush_tree_idle", {127'b0, mul_ready}, 128'd1);
    repeat (5) begin
      @(negedge clock);
      chk("flush_no_valid", {127'b0, out_valid}, 128'd0);
    end
    step();
    mul_valid = 1; flush = 1;
    step();
    chk("flush_idle_noacc", {127'b0, mul_ready}, 128'd1);
    mul_valid = 0; flush = 0;
    step();
    mul_valid = 1; multiplicand = 64'd5; multiplier = 64'd6;
    step();
    mul_valid = 0;
    step();
    reset = 1;
    step();
    chk("rst_add_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_add_ready", {127'b0, mul_ready}, 128'd1);
    chk("rst_add_result", {result_hi, result_lo}, 128'd0);
    reset = 0;
    step();
    for (int i = 0; i < 1500; i++) begin
      mul_valid = $urandom_range(0, 1);
      flush = $urandom_range(0, 15) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      mul_signed = 2'($urandom_range(0, 3));
      mulw = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: multiplicand = '1;
        1: multiplicand = 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 1)) << 31;
        default: multiplicand = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0: multiplier = '1;
        1: multiplier = 64'($urandom_range(0, 3));
        default: multiplier = {$urandom, $urandom};
      endcase
      step();
    end
    mul_valid = 0; flush = 0; out_ready = 1;
    repeat (6) step();
    armed = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
